// File: rtl/boot_loader.sv
// boot_loader: loads a big-endian byte-stream program image into memory, then hands the bus to the CPU.
// Define BOOT_LOADER_CHECKSUM_EN to require a modulo-256 checksum trailer byte after the image.
module boot_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_data_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              loading,
    output logic              load_error
);
    localparam logic [2:0] LEN_HI = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] WRITE  = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;
    localparam logic [2:0] DONE   = CHECK;
`else
    localparam logic [2:0] DONE   = RUN;
`endif

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ADDR_W:0]   ptr_nxt;
    logic              xfer, run;

    assign run     = state_q == RUN;
    assign xfer    = rx_valid & rx_ready;
    // One extra bit so the last-word test never wraps, even for N = 65535.
    assign ptr_nxt = {1'b0, ptr_q} + (ADDR_W + 1)'(1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    assign sum_d      = !xfer ? sum_q : (state_q == LEN_HI) ? rx_data : sum_q + rx_data;
    assign load_error = state_q == ERROR;
    assign rx_ready   = !reset && (state_q == LEN_HI || state_q == LEN_LO || state_q == DATA || state_q == CHECK);
`else
    assign load_error = 1'b0;
    assign rx_ready   = !reset && (state_q == LEN_HI || state_q == LEN_LO || state_q == DATA);
`endif

    assign cpu_reset   = reset || !run;
    assign loading     = reset || !run;
    assign mem_address = run ? cpu_address : ptr_q;
    assign mem_wdata   = run ? cpu_data_out : word_q;
    assign mem_we      = !reset && (run ? cpu_we : state_q == WRITE);
    assign cpu_data_in = mem_rdata;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            LEN_HI: if (xfer) begin
                len_d   = {rx_data, len_q[7:0]};
                state_d = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                len_d   = {len_q[15:8], rx_data};
                ptr_d   = '0;
                idx_d   = '0;
                state_d = (len_d == 16'd0) ? DONE : DATA;
            end
            DATA: if (xfer) begin
                word_d  = {word_q[DATA_W-9:0], rx_data};
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd3) ? WRITE : DATA;
            end
            WRITE: begin
                ptr_d   = ptr_nxt[ADDR_W-1:0];
                state_d = (ptr_nxt < (ADDR_W + 1)'(len_q)) ? DATA : DONE;
            end
            RUN: if (load_req) state_d = LEN_HI;
`ifdef BOOT_LOADER_CHECKSUM_EN
            CHECK: if (xfer) state_d = (rx_data == sum_q) ? RUN : ERROR;
            ERROR: if (load_req) state_d = LEN_HI;
`endif
            default: state_d = LEN_HI;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LEN_HI;
            len_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: drives byte-stream images with random gaps and load_req noise into boot_loader,
// predicting every cycle from the image layout; also checks the RUN pass-through with a vector table.
module tb_boot_loader;
    logic        clock = 1'b0;
    logic        reset, rx_valid, rx_ready, load_req, cpu_reset, cpu_we, mem_we, loading, load_error;
    logic [7:0]  rx_data;
    logic [15:0] cpu_address, mem_address;
    logic [31:0] cpu_data_out, cpu_data_in, mem_wdata, mem_rdata;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [7:0]  img [$];
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic        we;
        logic [15:0] ea;
        logic [31:0] ed;
        logic        ewe;
    } vec_t;
    vec_t vt [4];

    always #5 clock = ~clock;

    boot_loader dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .load_req(load_req), .cpu_reset(cpu_reset), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_we(cpu_we), .cpu_data_in(cpu_data_in), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .loading(loading), .load_error(load_error)
    );

    // Asynchronous-read memory, seeded with a recognisable pattern.
    assign mem_rdata = mem[mem_address[9:0]];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A0000 | 32'(i);
        forever begin
            @(posedge clock);
            if (mem_we) mem[mem_address[9:0]] = mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_trailer(input bit bad);
`ifdef BOOT_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'd0;
        foreach (img[i]) s = s + img[i];
        img.push_back(bad ? s + 8'd1 : s);
`else
        if (bad) $display("note: trailer requested without checksum build");
`endif
    endtask

    task automatic make_image(input int n, input bit bad);
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
        add_trailer(bad);
    endtask

    // Cycle-level prediction from the image layout: byte 2+4k+3 accepted -> write of word k next cycle.
    task automatic run_image(input int gap_pct, input bit exp_err);
        int n, total, pos, k, cyc;
        bit wp, fin;
        logic [31:0] wd;
        n = int'({img[0], img[1]});
        total = img.size();
        pos = 0; wp = 0; cyc = 0; k = 0; wd = '0;
        forever begin
            @(negedge clock);
            fin = (pos == total) && !wp;
            rx_valid = ($urandom_range(99) >= 32'(gap_pct));
            rx_data = (rx_valid && pos < total) ? img[pos] : 8'($urandom);
            load_req = fin ? 1'b0 : ($urandom_range(9) == 0);
            cpu_address = 16'($urandom);
            cpu_we = $urandom_range(1);
            #1;
            if (fin) begin
                chk("end_cpu_reset", cpu_reset, exp_err);
                chk("end_loading", loading, exp_err);
                chk("end_rx_ready", rx_ready, 0);
                chk("end_load_error", load_error, exp_err);
                chk("end_mem_we", mem_we, exp_err ? 1'b0 : cpu_we);
                break;
            end
            chk("ld_rx_ready", rx_ready, !wp);
            chk("ld_mem_we", mem_we, wp);
            chk("ld_cpu_reset", cpu_reset, 1);
            chk("ld_loading", loading, 1);
            if (wp) begin
                chk("wr_addr", mem_address, 32'(k));
                chk("wr_data", mem_wdata, wd);
                ref_mem[k[9:0]] = wd;
                wp = 0;
            end else if (rx_valid) begin
                if (pos >= 2 && pos < 2 + 4 * n && (pos - 2) % 4 == 3) begin
                    wp = 1;
                    k = (pos - 2) / 4;
                    wd = {img[pos-3], img[pos-2], img[pos-1], img[pos]};
                end
                pos++;
            end
            if (++cyc > 3000) begin
                chk("load_timeout", 0, 1);
                break;
            end
        end
        rx_valid = 0; load_req = 0; cpu_we = 0;
    endtask

    task automatic verify_mem(input int n);
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clock);
            cpu_address = 16'(k);
            cpu_we = 0;
            #1;
            chk("mem_word", cpu_data_in, ref_mem[k]);
        end
    endtask

    task automatic do_load_req();
        @(negedge clock);
        cpu_we = 0;
        load_req = 1;
        @(negedge clock);
        load_req = 0;
        #1;
        chk("lr_cpu_reset", cpu_reset, 1);
        chk("lr_rx_ready", rx_ready, 1);
        chk("lr_load_error", load_error, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h5A5A0000 | 32'(i);
        vt[0] = '{16'h0010, 32'hDEADBEEF, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b1};
        vt[1] = '{16'h0003, 32'h12345678, 1'b0, 16'h0003, 32'h12345678, 1'b0};
        vt[2] = '{16'h0020, 32'hCAFEF00D, 1'b1, 16'h0020, 32'hCAFEF00D, 1'b1};
        vt[3] = '{16'hFFFF, 32'h00000000, 1'b0, 16'hFFFF, 32'h00000000, 1'b0};
        reset = 1; rx_valid = 1; rx_data = 8'h00; load_req = 0;
        cpu_address = 16'h0; cpu_data_out = 32'h0; cpu_we = 1;
        repeat (2) begin
            @(negedge clock);
            #1;
            chk("rst_cpu_reset", cpu_reset, 1);
            chk("rst_loading", loading, 1);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_rx_ready", rx_ready, 0);
            chk("rst_load_error", load_error, 0);
        end
        reset = 0; rx_valid = 0; cpu_we = 0;
        @(negedge clock);
        #1;
        chk("post_rst_rx_ready", rx_ready, 1);
        chk("post_rst_mem_we", mem_we, 0);
        // Two-word example image, back to back.
        img = '{8'h00, 8'h02, 8'h40, 8'h00, 8'h00, 8'h05, 8'h70, 8'h00, 8'h00, 8'h10};
        add_trailer(0);
        run_image(0, 0);
        chk("ex_word0", ref_mem[0], 32'h40000005);
        chk("ex_word1", ref_mem[1], 32'h70000010);
        verify_mem(2);
        // Empty image.
        do_load_req();
        make_image(0, 0);
        run_image(0, 0);
        verify_mem(0);
        // Same two-word image with gaps.
        do_load_req();
        img = '{8'h00, 8'h02, 8'h40, 8'h00, 8'h00, 8'h05, 8'h70, 8'h00, 8'h00, 8'h10};
        add_trailer(0);
        run_image(50, 0);
        verify_mem(2);
        // RUN pass-through table.
        foreach (vt[i]) begin
            @(negedge clock);
            cpu_address = vt[i].a; cpu_data_out = vt[i].d; cpu_we = vt[i].we;
            #1;
            chk("pt_addr", mem_address, vt[i].ea);
            chk("pt_wdata", mem_wdata, vt[i].ed);
            chk("pt_we", mem_we, vt[i].ewe);
            chk("pt_rdata", cpu_data_in, mem[vt[i].a[9:0]]);
            chk("pt_cpu_reset", cpu_reset, 0);
            if (vt[i].we) ref_mem[vt[i].a[9:0]] = vt[i].d;
        end
        cpu_we = 0;
        verify_mem(34);
        // Reset after header plus three data bytes: no write, restart at LEN_HI.
        do_load_req();
        foreach (img[i]) if (i < 5) begin
            @(negedge clock);
            rx_valid = 1; rx_data = (i == 1) ? 8'h01 : img[i];
            #1;
            chk("part_mem_we", mem_we, 0);
        end
        @(negedge clock);
        reset = 1; rx_valid = 1; rx_data = 8'hEE;
        #1;
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_mem_we", mem_we, 0);
        @(negedge clock);
        reset = 0; rx_valid = 0;
        #1;
        chk("midrst_ready_after", rx_ready, 1);
        chk("midrst_loading", loading, 1);
        make_image(1, 0);
        run_image(20, 0);
        verify_mem(3);
        // Random images.
        for (int t = 0; t < 6; t++) begin
            do_load_req();
            make_image(int'($urandom_range(5)), 0);
            run_image(int'($urandom_range(60)), 0);
            verify_mem(7);
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        do_load_req();
        img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        run_image(0, 0);
        verify_mem(1);
        do_load_req();
        img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
        run_image(30, 1);
        repeat (3) begin
            @(negedge clock);
            rx_valid = 1;
            #1;
            chk("err_hold_cpu_reset", cpu_reset, 1);
            chk("err_hold_flag", load_error, 1);
            chk("err_hold_rx_ready", rx_ready, 0);
        end
        rx_valid = 0;
        do_load_req();
        make_image(3, 0);
        run_image(25, 0);
        verify_mem(4);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
